// File: rtl/gray_pkg.sv
// ============================================================================
// Module   : gray_pkg
// Purpose  : Shared types, width limits and Gray/binary helpers for the
//            up/down Gray counter family.
// Revision : 1.0
// ============================================================================
`default_nettype none

package gray_pkg;

  localparam int N_MIN = 2;
  localparam int N_MAX = 32;

  // Next-state selection for the counter register.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } op_e;

  // Helpers operate at the maximum width; narrower values are zero-extended.
  function automatic logic [N_MAX-1:0] bin2gray(input logic [N_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [N_MAX-1:0] gray2bin(input logic [N_MAX-1:0] g);
    logic [N_MAX-1:0] b;
    b[N_MAX-1] = g[N_MAX-1];
    for (int i = N_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_to_bin.sv
// ============================================================================
// Module   : gray_to_bin
// Purpose  : Combinational N-bit Gray-to-binary converter (prefix XOR from
//            the MSB).
// Revision : 1.0
// ============================================================================
`default_nettype none

module gray_to_bin #(
  parameter int N = 8
) (
  input  logic [N-1:0] gray,
  output logic [N-1:0] bin
);

  // Each binary bit is the parity of all Gray bits at or above it.
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign bin[i] = ^gray[N-1:i];
  end

endmodule

`default_nettype wire

// File: rtl/gray_counter_ud.sv
// ============================================================================
// Module   : gray_counter_ud
// Purpose  : N-bit up/down Gray counter with Gray-coded synchronous load,
//            registered binary mirror and terminal-count pulse.
//            Define GRAY_SAT_EN to add the sat port (saturate instead of wrap).
// Revision : 1.0
// ============================================================================
`default_nettype none

module gray_counter_ud
  import gray_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         up,
`ifdef GRAY_SAT_EN
  input  logic         sat,
`endif
  output logic [N-1:0] gray_out,
  output logic [N-1:0] bin_out,
  output logic         tc
);

  if (N < N_MIN || N > N_MAX) begin : g_bad_width
    $error("gray_counter_ud: N=%0d outside %0d..%0d", N, N_MIN, N_MAX);
  end

  logic [N-1:0] r_bin;
  logic [N-1:0] r_gray;
  logic         r_tc;

  logic [N-1:0] w_load_bin;
  logic [N-1:0] w_step_bin;
  logic [N-1:0] w_bin_nxt;
  logic [N-1:0] w_gray_nxt;
  logic         w_tc_nxt;
  logic         w_at_limit;
  logic         w_block;
  op_e          w_op;

  gray_to_bin #(.N(N)) u_load_conv (
    .gray (load_val),
    .bin  (w_load_bin)
  );

  assign w_at_limit = up ? (&r_bin) : ~(|r_bin);
  assign w_step_bin = up ? (r_bin + N'(1)) : (r_bin - N'(1));

`ifdef GRAY_SAT_EN
  assign w_block = sat & w_at_limit;
`else
  assign w_block = 1'b0;
`endif

  always_comb begin
    w_op = OP_HOLD;
    if (clk_en) begin
      if (load)    w_op = OP_LOAD;
      else if (up) w_op = OP_UP;
      else         w_op = OP_DOWN;
    end
  end

  always_comb begin
    w_bin_nxt = r_bin;
    w_tc_nxt  = 1'b0;
    case (w_op)
      OP_LOAD: w_bin_nxt = w_load_bin;
      OP_UP,
      OP_DOWN: begin
        // A blocked (saturated) step still flags the limit on tc.
        w_bin_nxt = w_block ? r_bin : w_step_bin;
        w_tc_nxt  = w_at_limit;
      end
      default: w_bin_nxt = r_bin;
    endcase
  end

  assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_tc   <= 1'b0;
    end else begin
      r_bin  <= w_bin_nxt;
      r_gray <= w_gray_nxt;
      r_tc   <= w_tc_nxt;
    end
  end

  assign gray_out = r_gray;
  assign bin_out  = r_bin;
  assign tc       = r_tc;

endmodule

`default_nettype wire

// File: tb/tb_gray_counter_ud.sv
// ============================================================================
// Module   : tb_gray_counter_ud
// Purpose  : Self-checking bench: three counter widths (8, 5, 4) share one
//            stimulus stream and are compared against an arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gray_counter_ud;

`ifdef GRAY_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b0;
  logic        load = 1'b0;
  logic        up = 1'b1;
  logic        sat = 1'b0;
  logic [31:0] lv = '0;

  wire [7:0] g8, b8;
  wire [4:0] g5, b5;
  wire [3:0] g4, b4;
  wire       t8, t5, t4;

  int n_chk = 0;
  int n_err = 0;

  int unsigned       widths [3] = '{8, 5, 4};
  longint unsigned   m_bin  [3];
  bit                m_tc   [3];
  bit                m_chg  [3];
  longint unsigned   prev_g [3];
  bit                was_count;

  always #5 clk = ~clk;

  gray_counter_ud #(.N(8)) u8 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .load(load), .load_val(lv[7:0]), .up(up),
`ifdef GRAY_SAT_EN
    .sat(sat),
`endif
    .gray_out(g8), .bin_out(b8), .tc(t8));

  gray_counter_ud #(.N(5)) u5 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .load(load), .load_val(lv[4:0]), .up(up),
`ifdef GRAY_SAT_EN
    .sat(sat),
`endif
    .gray_out(g5), .bin_out(b5), .tc(t5));

  gray_counter_ud #(.N(4)) u4 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .load(load), .load_val(lv[3:0]), .up(up),
`ifdef GRAY_SAT_EN
    .sat(sat),
`endif
    .gray_out(g4), .bin_out(b4), .tc(t4));

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned g2b(input longint unsigned g, input int w);
    longint unsigned b = 0;
    bit acc = 1'b0;
    for (int i = w - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

  task automatic obs(input int k, output longint unsigned g, output longint unsigned b,
                     output longint unsigned t);
    case (k)
      0:       begin g = g8; b = b8; t = t8; end
      1:       begin g = g5; b = b5; t = t5; end
      default: begin g = g4; b = b4; t = t4; end
    endcase
  endtask

  // Reference behaviour of one enabled/disabled edge, in plain arithmetic.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      longint unsigned mask = (64'd1 << widths[k]) - 1;
      longint unsigned old  = m_bin[k];
      if (!clk_en) begin
        m_tc[k] = 1'b0;
      end else if (load) begin
        m_bin[k] = g2b(lv & mask, widths[k]);
        m_tc[k]  = 1'b0;
      end else if (up) begin
        m_tc[k] = (old == mask);
        if (old != mask)           m_bin[k] = old + 1;
        else if (!(SAT_ON && sat)) m_bin[k] = 0;
      end else begin
        m_tc[k] = (old == 0);
        if (old != 0)              m_bin[k] = old - 1;
        else if (!(SAT_ON && sat)) m_bin[k] = mask;
      end
      m_chg[k] = (m_bin[k] != old);
    end
  endtask

  task automatic check_all(input string ph);
    longint unsigned g, b, t, eg;
    for (int k = 0; k < 3; k++) begin
      obs(k, g, b, t);
      eg = m_bin[k] ^ (m_bin[k] >> 1);
      chk($sformatf("%s_gray_n%0d", ph, widths[k]), g, eg);
      chk($sformatf("%s_bin_n%0d", ph, widths[k]), b, m_bin[k]);
      chk($sformatf("%s_tc_n%0d", ph, widths[k]), t, longint'(m_tc[k]));
      if (was_count)
        chk($sformatf("%s_hamming_n%0d", ph, widths[k]),
            longint'($countones(g ^ prev_g[k])), m_chg[k] ? 1 : 0);
      prev_g[k] = g;
    end
  endtask

  task automatic step(input bit en, input bit ld, input bit u, input logic [31:0] val,
                      input string ph);
    clk_en = en; load = ld; up = u; lv = val;
    @(posedge clk);
    model_edge();
    #1;
    was_count = en && !ld;
    check_all(ph);
  endtask

  // Assert rst between edges and check outputs clear before the next edge.
  task automatic async_reset(input string ph);
    clk_en = 1'b0; load = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      m_bin[k] = 0; m_tc[k] = 1'b0;
    end
    was_count = 1'b0;
    check_all(ph);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int tc_cnt;
    for (int k = 0; k < 3; k++) begin
      m_bin[k] = 0; m_tc[k] = 1'b0; m_chg[k] = 1'b0; prev_g[k] = 0;
    end
    was_count = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Count to 0x5A, then reset asynchronously mid-count.
    for (int i = 0; i < 'h5A; i++) step(1'b1, 1'b0, 1'b1, 32'h0, "cnt_up");
    chk("pre_rst_bin8", b8, 'h5A);
    async_reset("mid_rst");

    // Down wrap from reset.
    step(1'b1, 1'b0, 1'b0, 32'h0, "down_wrap");
    chk("down_wrap_bin4", b4, 'hF);
    chk("down_wrap_gray4", g4, 'h8);
    chk("down_wrap_tc4", t4, 1);

    // Up wrap on N=8 after loading Gray 0x80.
    step(1'b1, 1'b1, 1'b1, 32'h80, "load80");
    chk("load80_bin8", b8, 'hFF);
    step(1'b1, 1'b0, 1'b1, 32'h0, "up_wrap");
    chk("up_wrap_bin8", b8, 'h00);
    chk("up_wrap_tc8", t8, 1);
    step(1'b0, 1'b0, 1'b1, 32'h0, "after_wrap");
    chk("after_wrap_tc8", t8, 0);

    // Full cycle, N=5, up then down.
    async_reset("rst_cyc");
    tc_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b0, 1'b1, 32'h0, "cyc_up");
      tc_cnt += int'(t5);
    end
    chk("cyc_up_tc_pulses5", tc_cnt, 1);
    chk("cyc_up_end5", g5, 0);
    tc_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, "cyc_dn");
      tc_cnt += int'(t5);
    end
    chk("cyc_dn_tc_pulses5", tc_cnt, 1);
    chk("cyc_dn_end5", g5, 0);

    // Load priority over up, then load ignored while disabled.
    step(1'b1, 1'b1, 1'b1, 32'h1E, "ld_prio");
    chk("ld_prio_bin8", b8, 'h14);
    chk("ld_prio_tc8", t8, 0);
    step(1'b0, 1'b1, 1'b1, 32'h55, "ld_off");
    chk("ld_off_bin8", b8, 'h14);

    // Reload of the current value.
    step(1'b1, 1'b1, 1'b0, {24'h0, g8}, "reload");
    chk("reload_bin8", b8, 'h14);

`ifdef GRAY_SAT_EN
    // Saturation at the top on N=4: load Gray 0x8 (binary 0xF).
    sat = 1'b1;
    step(1'b1, 1'b1, 1'b1, 32'h8, "sat_ld");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 32'h0, "sat_up");
      chk("sat_up_bin4", b4, 'hF);
      chk("sat_up_tc4", t4, 1);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0, "sat_dn");
    chk("sat_dn_bin4", b4, 'hE);
    chk("sat_dn_tc4", t4, 0);
    sat = 1'b0;
`endif

    // Randomised traffic, occasionally steering to the wrap limits.
    for (int i = 0; i < 400; i++) begin
      bit          en, ld, u;
      logic [31:0] val;
      en  = ($urandom_range(0, 3) != 0);
      ld  = ($urandom_range(0, 9) == 0);
      u   = $urandom_range(0, 1) != 0;
      val = $urandom;
      if ($urandom_range(0, 15) == 0) val = 32'h80;
      if ($urandom_range(0, 15) == 0) val = {24'h0, g8};
      if (SAT_ON) sat = $urandom_range(0, 1) != 0;
      step(en, ld, u, val, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
